// File: rtl/buzzer_pkg.sv
// Shared types for the buzzer output stage: FSM states, channel codes and
// the alarm-to-channel priority map.
package buzzer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TONE_ON = 2'd1,
      GAP     = 2'd2
   } state_e;

   localparam logic [1:0] CH_NONE = 2'd0;
   localparam logic [1:0] CH_1    = 2'd1;
   localparam logic [1:0] CH_2    = 2'd2;
   localparam logic [1:0] CH_3    = 2'd3;

   // Highest set enable wins.
   function automatic logic [1:0] sel_chan(input logic [2:0] alarm);
      logic [1:0] ch;
      if (alarm[2])      ch = CH_3;
      else if (alarm[1]) ch = CH_2;
      else if (alarm[0]) ch = CH_1;
      else               ch = CH_NONE;
      return ch;
   endfunction

endpackage

// File: rtl/buzzer_tone_gen_tone_divider.sv
// Half-period down-counter with toggle flop; the tone is forced low
// whenever it is neither loading nor running.
module tone_divider #(
   parameter int CNT_W = 24
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ena_i,
   input  logic             load_i,
   input  logic             run_i,
   input  logic [CNT_W-1:0] half_val_i,
   output logic             tone_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tone_q, tone_d;

   always_comb begin
      cnt_d  = cnt_q;
      tone_d = tone_q;
      if (ena_i) begin
         if (load_i) begin
            cnt_d  = half_val_i - CNT_W'(1);
            tone_d = 1'b0;
         end else if (run_i) begin
            if (cnt_q == '0) begin
               cnt_d  = half_val_i - CNT_W'(1);
               tone_d = ~tone_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end else begin
            cnt_d  = '0;
            tone_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tone_q <= tone_d;
      end
   end

   assign tone_o = tone_q;
   assign tc_o   = (cnt_q == '0);

endmodule

// File: rtl/buzzer_tone_gen.sv
// Piezo output stage: per-channel square wave with on/off beep cadence.
//   state   | meaning
//   IDLE    | no alarm, both pins low
//   TONE_ON | square wave on tone_out, complement on tone_out_n
//   GAP     | silent part of a ch2/ch3 beep, both pins low
module buzzer_tone_gen
   import buzzer_pkg::*;
#(
   parameter int CNT_W      = 24,
   parameter int HALF_1     = 12500,
   parameter int HALF_2     = 8333,
   parameter int HALF_3     = 6250,
   parameter int BEEP_ON_2  = 12500000,
   parameter int BEEP_OFF_2 = 12500000,
   parameter int BEEP_ON_3  = 5000000,
   parameter int BEEP_OFF_3 = 2500000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ena_i,
   input  logic [2:0] alarm_in_i,
   output logic       tone_out_o,
   output logic       tone_out_n_o,
   output logic       active_o,
   output logic [1:0] chan_o
);

   state_e           state_q, state_d;
   logic [1:0]       chan_q, chan_d;
   logic [CNT_W-1:0] beep_q, beep_d;
   logic             tone_n_q, tone_n_d;
   logic [1:0]       sel;
   logic             load, run, enter, tc, tone;
   logic [CNT_W-1:0] half_val;

   function automatic logic [CNT_W-1:0] half_of(input logic [1:0] ch);
      case (ch)
         CH_1:    return CNT_W'(HALF_1);
         CH_2:    return CNT_W'(HALF_2);
         default: return CNT_W'(HALF_3);
      endcase
   endfunction

   // ch1 has no cadence; its beep count is parked at zero.
   function automatic logic [CNT_W-1:0] on_of(input logic [1:0] ch);
      case (ch)
         CH_2:    return CNT_W'(BEEP_ON_2);
         CH_3:    return CNT_W'(BEEP_ON_3);
         default: return CNT_W'(1);
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] off_of(input logic [1:0] ch);
      if (ch == CH_2) return CNT_W'(BEEP_OFF_2);
      else            return CNT_W'(BEEP_OFF_3);
   endfunction

   assign sel = sel_chan(alarm_in_i);

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      beep_d   = beep_q;
      tone_n_d = tone_n_q;
      load     = 1'b0;
      run      = 1'b0;
      enter    = 1'b0;
      if (ena_i) begin
         if (sel == CH_NONE) begin
            state_d  = IDLE;
            chan_d   = CH_NONE;
            beep_d   = '0;
            tone_n_d = 1'b0;
         end else if (state_q == IDLE || sel != chan_q) begin
            enter = 1'b1;
         end else begin
            case (state_q)
               TONE_ON: begin
                  run      = 1'b1;
                  tone_n_d = tc ? ~tone_n_q : tone_n_q;
                  if (chan_q != CH_1) begin
                     if (beep_q == '0) begin
                        state_d  = GAP;
                        beep_d   = off_of(chan_q) - CNT_W'(1);
                        run      = 1'b0;
                        tone_n_d = 1'b0;
                     end else begin
                        beep_d = beep_q - CNT_W'(1);
                     end
                  end
               end
               GAP: begin
                  tone_n_d = 1'b0;
                  if (beep_q == '0) enter = 1'b1;
                  else              beep_d = beep_q - CNT_W'(1);
               end
               default: state_d = IDLE;
            endcase
         end
         if (enter) begin
            state_d  = TONE_ON;
            chan_d   = sel;
            beep_d   = on_of(sel) - CNT_W'(1);
            load     = 1'b1;
            run      = 1'b0;
            tone_n_d = 1'b1;
         end
      end
   end

   assign half_val = load ? half_of(sel) : half_of(chan_q);

   tone_divider #(.CNT_W(CNT_W)) u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .ena_i      (ena_i),
      .load_i     (load),
      .run_i      (run),
      .half_val_i (half_val),
      .tone_o     (tone),
      .tc_o       (tc)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         chan_q   <= CH_NONE;
         beep_q   <= '0;
         tone_n_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         beep_q   <= beep_d;
         tone_n_q <= tone_n_d;
      end
   end

   assign tone_out_o   = tone;
   assign tone_out_n_o = tone_n_q;
   assign active_o     = (state_q != IDLE);
   assign chan_o       = chan_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen with shortened tone and cadence lengths.
module tb_buzzer_tone_gen;

   localparam int H1 = 4, H2 = 3, H3 = 2;
   localparam int ON2 = 12, OFF2 = 12, ON3 = 6, OFF3 = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [2:0] alarm;
   logic       tone_out, tone_out_n, active;
   logic [1:0] chan;

   int tests = 0;
   int fails = 0;

   buzzer_tone_gen #(
      .CNT_W(24), .HALF_1(H1), .HALF_2(H2), .HALF_3(H3),
      .BEEP_ON_2(ON2), .BEEP_OFF_2(OFF2), .BEEP_ON_3(ON3), .BEEP_OFF_3(OFF3)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ena_i        (ena),
      .alarm_in_i   (alarm),
      .tone_out_o   (tone_out),
      .tone_out_n_o (tone_out_n),
      .active_o     (active),
      .chan_o       (chan)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] alarm;
      logic       ena;
      logic       tone;
      logic       tone_n;
      logic       active;
      logic [1:0] chan;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input logic t, input logic tn,
                          input logic a, input logic [1:0] c);
      chk({name, ".tone_out"}, int'(tone_out), int'(t));
      chk({name, ".tone_out_n"}, int'(tone_out_n), int'(tn));
      chk({name, ".active"}, int'(active), int'(a));
      chk({name, ".chan"}, int'(chan), int'(c));
   endtask

   // Expected {tone, tone_n} k cycles after the entry edge of a channel.
   function automatic logic [1:0] exp_pins(input int ch, input int k);
      int h, on, off, m;
      logic t;
      h   = (ch == 1) ? H1 : (ch == 2) ? H2 : H3;
      on  = (ch == 2) ? ON2 : ON3;
      off = (ch == 2) ? OFF2 : OFF3;
      if (ch == 1) begin
         t = ((k / h) % 2) == 1;
         return {t, ~t};
      end
      m = k % (on + off);
      if (m < on) begin
         t = ((m / h) % 2) == 1;
         return {t, ~t};
      end
      return 2'b00;
   endfunction

   task automatic run_chk(input string name, input int ch, input int n);
      logic [1:0] e;
      for (int k = 0; k < n; k++) begin
         step();
         e = exp_pins(ch, k);
         chk_all($sformatf("%s[k=%0d]", name, k), e[1], e[0], 1'b1, 2'(ch));
      end
   endtask

   initial begin
      // ch2 priority, mid-burst freeze (alarm change while frozen is ignored), gap, clear
      vecs[0]  = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[1]  = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[2]  = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[3]  = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
      vecs[4]  = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
      for (int i = 5; i < 12; i++)
         vecs[i] = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
      vecs[8].alarm = 3'b000;
      vecs[12] = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
      vecs[13] = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[14] = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[15] = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[16] = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
      vecs[17] = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
      vecs[18] = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
      vecs[19] = '{3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
      vecs[20] = '{3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
      vecs[21] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};

      // 1: reset with all alarms asserted, then release
      rst_n = 1'b0;
      ena   = 1'b1;
      alarm = 3'b111;
      repeat (3) step();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 2'd0);
      #3 rst_n = 1'b1;
      run_chk("s1_ch3", 3, 20);

      // 2: continuous ch1
      alarm = 3'b001;
      run_chk("s2_ch1", 1, 40);

      // 3: ch2 cadence
      alarm = 3'b010;
      run_chk("s3_ch2", 2, 60);

      // 4: switch mid-high-phase to ch3, then clear
      alarm = 3'b001;
      run_chk("s4_ch1", 1, 6);
      chk("s4_mid_high", int'(tone_out), 1);
      alarm = 3'b100;
      run_chk("s4_ch3", 3, 6);
      alarm = 3'b000;
      step();
      chk_all("s4_clear", 1'b0, 1'b0, 1'b0, 2'd0);

      // 5: table
      for (int i = 0; i < 22; i++) begin
         alarm = vecs[i].alarm;
         ena   = vecs[i].ena;
         step();
         chk_all($sformatf("s5_vec%0d", i), vecs[i].tone, vecs[i].tone_n,
                 vecs[i].active, vecs[i].chan);
      end
      ena = 1'b1;

      // 6: async reset pulse between edges during ch3 tone
      alarm = 3'b100;
      run_chk("s6_pre", 3, 4);
      chk("s6_pre_high", int'(tone_out), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_all("s6_async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
      #2 rst_n = 1'b1;
      run_chk("s6_restart", 3, 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/buzzer_tone_gen.md
Name: buzzer_tone_gen

Overview:
- Downstream stage of the sensor/buzzer alarm controller.
- Consumes its three level-type buzzer enables and drives a piezo pin pair with a per-channel audio square wave and on/off cadence.
- Channel 1 sounds continuously; channels 2 and 3 beep with their own cadences, so a listener can tell the three alarms apart.
- Pure output stage: no sensing and no alarm timing of its own.

Parameters:
- CNT_W, 24, width of all internal counters.
- HALF_1, 12500, half-period in clk cycles for channel 1 tone (2 kHz at 50 MHz).
- HALF_2, 8333, half-period for channel 2 (3 kHz).
- HALF_3, 6250, half-period for channel 3 (4 kHz).
- BEEP_ON_2, 12500000, tone-on cycles per beep, channel 2.
- BEEP_OFF_2, 12500000, silent cycles per beep, channel 2.
- BEEP_ON_3, 5000000, tone-on cycles per beep, channel 3.
- BEEP_OFF_3, 2500000, silent cycles per beep, channel 3.
- Legal values: all parameters ≥ 2 and < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- ena  in  1  clock enable. When low, every register holds its value.
- alarm_in  in  3  buzzer enables from the controller; bit0=ch1, bit1=ch2, bit2=ch3; levels, nominally one-hot.
- tone_out  out  1  piezo drive, positive side.
- tone_out_n  out  1  piezo drive, negative side.
- active  out  1  high when state != IDLE.
- chan  out  2  channel currently sounding; 0 when idle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, chan=0, tone_out=0, tone_out_n=0, active=0, all counters 0. Outputs clear without a clock edge.
- Channel select (combinational on alarm_in): highest set bit wins, so 1xx->3, 01x->2, 001->1, 000->0.
- All outputs are registered. tone_out_n = ~tone_out in TONE_ON, and 0 in IDLE and GAP, so there is no DC across the piezo.
- States: IDLE, TONE_ON, GAP. Transitions are evaluated only when ena=1.
- IDLE:
  - sel!=0 -> TONE_ON.
  - Load chan=sel, half_cnt=HALF_sel-1, beep_cnt=BEEP_ON_sel-1 (unused for ch1).
  - tone_out=0; tone_out_n=1 from the same edge.
- TONE_ON:
  - half_cnt decrements each cycle. At 0: toggle tone_out and reload HALF_chan-1.
  - First rising edge of tone_out lands exactly HALF_chan cycles after entry. Period = 2*HALF_chan cycles.
  - ch2/ch3: beep_cnt decrements. At 0 -> GAP, tone_out=0, beep_cnt=BEEP_OFF_chan-1.
  - ch1 never leaves TONE_ON on cadence.
- GAP:
  - beep_cnt decrements. At 0 -> TONE_ON with the same entry loads as from IDLE; tone restarts low.
- Any state with sel=0 -> IDLE next edge, all outputs 0.
- Any state with sel!=0 and sel!=chan: same edge enters TONE_ON with the new channel's entry loads. Phase and cadence restart; there is no glitch longer than one cycle.
- Priority on simultaneous events: sel change/clear overrides a cadence or half-period expiry on the same edge.
- ena=0: all registers hold, outputs frozen. Resuming continues from the held counts.
- Counters never wrap, because they reload at 0.

Decomposition:
- Shared package buzzer_pkg holds:
  - the state enum (IDLE, TONE_ON, GAP);
  - channel codes CH_NONE=0, CH_1..CH_3;
  - the function mapping alarm_in to the channel code.
- One sub-module, tone_divider. It contains the half-period down-counter and the toggle flop, with inputs load, half_val and run, and output tone.
- The top level keeps the FSM, the beep counter and the output gating.

Test Plan (override parameters: HALF_1=4, HALF_2=3, HALF_3=2, BEEP_ON_2=12, BEEP_OFF_2=12, BEEP_ON_3=6, BEEP_OFF_3=4):
1. rst_n=0 with alarm_in=111 and clk running -> tone_out, tone_out_n, active, chan all 0. Release -> first edge enters TONE_ON, chan=3.
2. alarm_in=001 held 40 cycles -> chan=1, active=1, tone_out low 4 / high 4 repeating, no gaps, tone_out_n is its exact complement.
3. alarm_in=010 held 60 cycles -> toggle every 3 cycles for 12 cycles, then both pins 0 for 12 cycles, repeating. Each ON burst starts low.
4. alarm_in=001, switch to 100 mid-high-phase -> next edge chan=3, tone_out=0, toggles every 2 cycles. Then alarm_in=000 -> next edge IDLE, all outputs 0.
5. alarm_in=011 -> chan=2 (priority). Then ena=0 for 7 cycles mid-burst -> outputs frozen. ena=1 -> burst completes its remaining on-count.
6. Async rst_n pulse between clock edges during TONE_ON with ch3 -> outputs 0 before the next edge. Restart after release with alarm_in=100 -> timing matches scenario 1.
